memory_arbiter: RTL and testbench

Sequences the single external data/instruction memory port among three pipeline requesters: fetch (instruction read), read stage (data read) and write stage (data write). Fixed priority, one transaction in flight, Avalon-MM style master on the memory side. Each requester sees a request/`data_valid` handshake: it holds its request until `data_valid`, then advances. Includes a watchdog that completes hung transactions with an error.

---
 rtl/memory_arbiter_pkg.sv | 25 ++
 rtl/memory_arbiter.sv | 174 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: register value type, requester
// indices and the arbiter FSM state encoding.
package memory_arbiter_pkg;

  typedef logic [31:0] regval_t;

  localparam int unsigned NRQ      = 3;
  localparam int unsigned ReqFetch = 0;
  localparam int unsigned ReqRead  = 1;
  localparam int unsigned ReqWrite = 2;

  typedef logic [1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  function automatic logic [NRQ-1:0] owner_onehot(input req_idx_t idx);
    return NRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Fixed-priority arbiter sequencing fetch, read and write requesters onto a
// single Avalon-MM style memory port, with a watchdog for hung transactions.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NRQ-1:0]          request,
  input  regval_t [NRQ-1:0]       address,
  input  regval_t                 write_data,
  output logic [NRQ-1:0]          data_valid,
  output logic                    error,
  output regval_t                 read_data,
  output regval_t                 mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output regval_t                 mem_writedata,
  input  logic                    mem_waitrequest,
  input  regval_t                 mem_readdata,
  input  logic                    mem_readdatavalid
);

  localparam logic [15:0] WdLast = 16'(TimeoutCycles - 1);

  arb_state_t      state, state_next;
  req_idx_t        owner, owner_next;
  logic [15:0]     wd, wd_next;
  logic            stale, stale_next;
  logic            mem_read_next, mem_write_next;
  regval_t         mem_address_next, mem_writedata_next;
  logic [NRQ-1:0]  data_valid_next;
  logic            error_next;
  regval_t         read_data_next;

  logic            grant_valid;
  req_idx_t        grant;
  logic            wd_expired;
  logic            resp_live;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= req_idx_t'(ReqFetch);
      wd            <= '0;
      stale         <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      data_valid    <= '0;
      error         <= 1'b0;
      read_data     <= '0;
    end else begin
      state         <= state_next;
      owner         <= owner_next;
      wd            <= wd_next;
      stale         <= stale_next;
      mem_read      <= mem_read_next;
      mem_write     <= mem_write_next;
      mem_address   <= mem_address_next;
      mem_writedata <= mem_writedata_next;
      data_valid    <= data_valid_next;
      error         <= error_next;
      read_data     <= read_data_next;
    end
  end

  // While a timed-out read is still outstanding only a write may win.
  always_comb begin
    grant_valid = 1'b0;
    grant       = req_idx_t'(ReqFetch);
    if (request[ReqWrite]) begin
      grant_valid = 1'b1;
      grant       = req_idx_t'(ReqWrite);
    end else if (!stale && request[ReqRead]) begin
      grant_valid = 1'b1;
      grant       = req_idx_t'(ReqRead);
    end else if (!stale && request[ReqFetch]) begin
      grant_valid = 1'b1;
      grant       = req_idx_t'(ReqFetch);
    end
  end

  always_comb begin
    state_next         = state;
    owner_next         = owner;
    wd_next            = wd;
    stale_next         = stale;
    mem_read_next      = mem_read;
    mem_write_next     = mem_write;
    mem_address_next   = mem_address;
    mem_writedata_next = mem_writedata;
    data_valid_next    = '0;
    error_next         = 1'b0;
    read_data_next     = read_data;

    wd_expired = (wd >= WdLast);
    resp_live  = mem_readdatavalid && !stale;

    // The late response of a timed-out read is swallowed wherever it lands.
    if (stale && mem_readdatavalid) begin
      stale_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next       = ISSUE;
          owner_next       = grant;
          wd_next          = '0;
          mem_address_next = address[grant];
          if (grant == req_idx_t'(ReqWrite)) begin
            mem_write_next     = 1'b1;
            mem_writedata_next = write_data;
          end else begin
            mem_read_next = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (!mem_waitrequest) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          if (mem_write) begin
            state_next      = DONE;
            data_valid_next = owner_onehot(owner);
          end else if (resp_live) begin
            state_next      = DONE;
            data_valid_next = owner_onehot(owner);
            read_data_next  = mem_readdata;
          end else begin
            state_next = WAIT;
            wd_next    = wd + 16'd1;
          end
        end else if (wd_expired) begin
          mem_read_next   = 1'b0;
          mem_write_next  = 1'b0;
          state_next      = DONE;
          data_valid_next = owner_onehot(owner);
          error_next      = 1'b1;
        end else begin
          wd_next = wd + 16'd1;
        end
      end

      WAIT: begin
        if (resp_live) begin
          state_next      = DONE;
          data_valid_next = owner_onehot(owner);
          read_data_next  = mem_readdata;
        end else if (wd_expired) begin
          state_next      = DONE;
          data_valid_next = owner_onehot(owner);
          error_next      = 1'b1;
          stale_next      = 1'b1;
        end else begin
          wd_next = wd + 16'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a small memory responder.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NRQ-1:0]    request = '0;
  regval_t [NRQ-1:0] address = '0;
  regval_t           write_data = '0;
  logic [NRQ-1:0]    data_valid;
  logic              error;
  regval_t           read_data;
  regval_t           mem_address;
  logic              mem_read;
  logic              mem_write;
  regval_t           mem_writedata;
  logic              mem_waitrequest = 1'b0;
  regval_t           mem_readdata;
  logic              mem_readdatavalid;

  logic    auto_rdv = 1'b0;
  regval_t auto_data = '0;
  logic    man_rdv = 1'b0;
  regval_t man_data = '0;
  int      resp_latency = 0;
  regval_t resp_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  assign mem_readdatavalid = auto_rdv | man_rdv;
  assign mem_readdata      = auto_rdv ? auto_data : man_data;

  memory_arbiter #(.TimeoutCycles(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .request           (request),
    .address           (address),
    .write_data        (write_data),
    .data_valid        (data_valid),
    .error             (error),
    .read_data         (read_data),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Read responder: answers an accepted read resp_latency cycles later (0 = silent).
  initial begin
    logic acc;
    int   resp_cnt;
    resp_cnt = 0;
    forever begin
      @(posedge clock);
      acc = mem_read && !mem_waitrequest;
      #1;
      auto_rdv = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          auto_rdv  = 1'b1;
          auto_data = resp_data;
        end
      end
      if (acc && resp_latency > 0) begin
        resp_cnt = resp_latency - 1;
        if (resp_cnt == 0) begin
          auto_rdv  = 1'b1;
          auto_data = resp_data;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic          ok;
    logic [NRQ-1:0] exp_dv;

    // Reset and idle
    repeat (3) tick();
    reset = 1'b0;
    check("rst_data_valid", data_valid, 3'b000);
    check("rst_error", error, 0);
    check("rst_read_data", read_data, 0);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_writedata", mem_writedata, 0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok &= !mem_read && !mem_write && (data_valid == 3'b000);
      tick();
    end
    check("idle_no_strobe", ok, 1);

    // Simultaneous requests, zero-wait memory, 1-cycle read latency
    resp_latency = 1;
    resp_data    = 32'hA5A5_0200;
    address[ReqFetch] = 32'h0000_0100;
    address[ReqRead]  = 32'h0000_0200;
    address[ReqWrite] = 32'h0000_0300;
    write_data = 32'hCAFE_0300;
    request    = 3'b111;
    for (int c = 0; c < 12; c++) begin
      exp_dv = (c == 2) ? 3'b100 : (c == 6) ? 3'b010 : (c == 10) ? 3'b001 : 3'b000;
      check($sformatf("prio_dv_c%0d", c), data_valid, exp_dv);
      if (c == 1) check("prio_wr_cmd", {mem_write, mem_read, mem_address, mem_writedata},
                        {2'b10, 32'h0000_0300, 32'hCAFE_0300});
      if (c == 4) check("prio_rd_cmd", {mem_write, mem_read, mem_address}, {2'b01, 32'h0000_0200});
      if (c == 6) begin
        check("prio_rd_data", read_data, 32'hA5A5_0200);
        resp_data = 32'hA5A5_0100;
      end
      if (c == 8) check("prio_fetch_cmd", {mem_write, mem_read, mem_address}, {2'b01, 32'h0000_0100});
      if (c == 10) check("prio_fetch_data", read_data, 32'hA5A5_0100);
      request = request & ~data_valid;
      tick();
    end

    // Write with 3 wait-request cycles
    request = 3'b100;
    address[ReqWrite] = 32'h0000_1000;
    write_data = 32'hDEAD_BEEF;
    mem_waitrequest = 1'b1;
    tick();
    ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_waitrequest = 1'b0;
      ok &= mem_write && !mem_read && (mem_address == 32'h0000_1000)
            && (mem_writedata == 32'hDEAD_BEEF) && (data_valid == 3'b000);
      tick();
    end
    check("wr_wait_stable", ok, 1);
    check("wr_wait_dv", data_valid, 3'b100);
    check("wr_wait_cmd_drop", mem_write, 0);
    request = 3'b000;
    tick();

    // Fetch with 5-cycle memory latency
    resp_latency = 5;
    resp_data    = 32'h1234_5678;
    address[ReqFetch] = 32'h0000_0040;
    request = 3'b001;
    tick();
    check("fetch_cmd", {mem_read, mem_address}, {1'b1, 32'h0000_0040});
    repeat (5) tick();
    check("fetch_dv_early", data_valid, 3'b000);
    check("fetch_data_early", read_data, 32'hA5A5_0100);
    tick();
    check("fetch_dv", data_valid, 3'b001);
    check("fetch_data", read_data, 32'h1234_5678);
    request = 3'b000;
    repeat (3) tick();
    check("fetch_data_held", {data_valid, read_data}, {3'b000, 32'h1234_5678});

    // Read timeout in WAIT, late response discarded, fetch held off meanwhile
    resp_latency = 0;
    address[ReqRead] = 32'h0000_0080;
    request = 3'b010;
    tick();
    check("to_rd_cmd", mem_read, 1);
    tick();
    check("to_rd_accepted", mem_read, 0);
    repeat (6) tick();
    check("to_dv_early", data_valid, 3'b000);
    tick();
    check("to_dv", {data_valid, error}, {3'b010, 1'b1});
    check("to_data_unchanged", read_data, 32'h1234_5678);
    request = 3'b001;
    address[ReqFetch] = 32'h0000_0044;
    tick();
    check("to_error_clear", {data_valid, error}, {3'b000, 1'b0});
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ok &= !mem_read;
      tick();
    end
    check("stale_blocks_fetch", ok, 1);
    man_data = 32'hBAD0_BAD0;
    man_rdv  = 1'b1;
    tick();
    man_rdv = 1'b0;
    check("stale_no_issue_yet", mem_read, 0);
    resp_latency = 1;
    resp_data    = 32'h600D_F00D;
    tick();
    check("stale_fetch_cmd", {mem_read, mem_address}, {1'b1, 32'h0000_0044});
    check("stale_data_discarded", read_data, 32'h1234_5678);
    repeat (2) tick();
    check("stale_fetch_dv", {data_valid, error}, {3'b001, 1'b0});
    check("stale_fetch_data", read_data, 32'h600D_F00D);
    request = 3'b000;
    tick();

    // Write timeout in ISSUE (waitrequest stuck); no stale afterwards
    resp_latency = 0;
    address[ReqWrite] = 32'h0000_3000;
    write_data = 32'h0F0F_0F0F;
    mem_waitrequest = 1'b1;
    request = 3'b100;
    tick();
    repeat (7) tick();
    check("iss_to_cmd_held", {mem_write, mem_address}, {1'b1, 32'h0000_3000});
    tick();
    check("iss_to_dv", {data_valid, error, mem_write}, {3'b100, 1'b1, 1'b0});
    check("iss_to_data_unchanged", read_data, 32'h600D_F00D);
    mem_waitrequest = 1'b0;
    request = 3'b001;
    address[ReqFetch] = 32'h0000_0048;
    resp_latency = 1;
    resp_data    = 32'h7777_1111;
    repeat (2) tick();
    check("iss_to_next_fetch", {mem_read, mem_address}, {1'b1, 32'h0000_0048});
    repeat (2) tick();
    check("iss_to_next_dv", {data_valid, error}, {3'b001, 1'b0});
    check("iss_to_next_data", read_data, 32'h7777_1111);
    request = 3'b000;
    tick();

    // Reset during WAIT, then a normal write
    resp_latency = 0;
    address[ReqRead] = 32'h0000_0090;
    request = 3'b010;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_wait_outputs", {mem_read, mem_write, data_valid, error},
          {1'b0, 1'b0, 3'b000, 1'b0});
    check("rst_wait_regs", {read_data, mem_address}, 64'h0);
    reset = 1'b0;
    request = 3'b100;
    address[ReqWrite] = 32'h0000_2000;
    write_data = 32'h5555_AAAA;
    tick();
    check("post_rst_wr_cmd", {mem_write, mem_read, mem_address, mem_writedata},
          {2'b10, 32'h0000_2000, 32'h5555_AAAA});
    tick();
    check("post_rst_wr_dv", {data_valid, error}, {3'b100, 1'b0});
    request = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
